apb_master_bridge: RTL and testbench

//  APB3 requester: converts one-at-a-time valid/ready commands into APB SETUP/ACCESS transfers.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_bridge.sv | 109 ++++++++++
 tb/tb_apb_master_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 12;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Every output is a flop, so nothing combinational reaches the ports from any input.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,

    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    apb_mst_state_e  state_q;
    logic [CntW-1:0] wait_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state_q     <= SETUP;
                        cmd_ready_o <= 1'b0;
                        psel_o      <= 1'b1;
                        penable_o   <= 1'b0;
                        pwrite_o    <= cmd_write_i;
                        paddr_o     <= cmd_addr_i;
                        pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
                    end
                end

                SETUP: begin
                    state_q   <= ACCESS;
                    penable_o <= 1'b1;
                end

                ACCESS: begin
                    // A ready on the last allowed edge completes normally rather than aborting.
                    if (pready_i) begin
                        state_q     <= RESP;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                        rsp_err_o   <= pslverr_i;
                    end else if (wait_cnt_q == CntLast) begin
                        state_q     <= RESP;
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_o <= 1'b0;
                        wait_cnt_q  <= '0;
                        cmd_ready_o <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized transfers against a memory-backed APB slave and a reference memory.
module tb_apb_master_bridge;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          s_waits = 0;
    logic        s_err = 1'b0;
    logic        s_hang = 1'b0;
    logic        s_tie = 1'b0;
    int          acc_cnt = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int compared = 0;
    int mismatched = 0;

    apb_master_bridge #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write),
        .cmd_addr_i (cmd_addr),
        .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .paddr_o    (paddr),
        .pwdata_o   (pwdata),
        .prdata_i   (prdata),
        .pready_i   (pready),
        .pslverr_i  (pslverr)
    );

    always #5 clk = ~clk;

    // Slave: ready after s_waits stalled ACCESS cycles; tie mode asserts ready everywhere.
    assign pready  = s_tie | (psel && penable && !s_hang && (acc_cnt == s_waits));
    assign pslverr = s_err && pready;
    assign prdata  = mem[paddr[11:2]];

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && !pslverr) mem[paddr[11:2]] <= pwdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                          input int waits, input logic err, input logic hang,
                          input logic tie, input int hold);
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic        exp_err;
        int          exp_acc;
        int          acc;
        logic        done;
        s_waits = waits; s_err = err; s_hang = hang; s_tie = tie;
        exp_err = hang | err;
        exp_rd  = (hang || wr) ? 32'h0 : ref_mem[addr[11:2]];
        exp_wd  = wr ? wd : 32'h0;
        exp_acc = hang ? TO : waits + 1;
        if (wr && !exp_err) ref_mem[addr[11:2]] = wd;

        chk("idle_ready", {cmd_ready, psel, rsp_valid}, 3'b100);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 12'($urandom); cmd_wdata = $urandom; cmd_write = ~wr;
        chk("setup_phase", {psel, penable, pwrite, paddr, pwdata, cmd_ready, rsp_valid},
            {1'b1, 1'b0, wr, addr, exp_wd, 1'b0, 1'b0});
        @(posedge clk); #1;
        acc = 0; done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                acc++;
                chk("access_phase", {psel, penable, pwrite, paddr, pwdata, cmd_ready},
                    {1'b1, 1'b1, wr, addr, exp_wd, 1'b0});
                @(posedge clk); #1;
            end
        end
        if (!done) chk("rsp_never_valid", 1'b0, 1'b1);
        chk("access_cycles", 128'(acc), 128'(exp_acc));
        chk("rsp_data", {rsp_valid, rsp_rdata, rsp_err, psel, penable, cmd_ready},
            {1'b1, exp_rd, exp_err, 1'b0, 1'b0, 1'b0});
        // Offer a competing command while the response is held; it must be ignored.
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            chk("rsp_hold", {rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel},
                {1'b1, exp_rd, exp_err, 1'b0, 1'b0});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_taken", {rsp_valid, cmd_ready, psel}, 3'b010);
        s_tie = 1'b0; s_err = 1'b0; s_hang = 1'b0;
    endtask

    initial begin
        logic        wr;
        logic [11:0] addr;
        logic        hang;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        #12;
        chk("reset_state",
            {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, cmd_ready},
            {3'b000, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1});
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait write with pready tied high, then reads with wait states.
        do_txn(1'b1, 12'h010, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b1, 0);
        do_txn(1'b0, 12'h010, 32'h0, 2, 1'b0, 1'b0, 1'b0, 0);
        // Slave error, then a clean read.
        do_txn(1'b1, 12'h3FC, 32'h12345678, 1, 1'b1, 1'b0, 1'b0, 0);
        do_txn(1'b0, 12'h004, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1);
        // Hung slave times out; ready on the boundary edge still completes.
        do_txn(1'b0, 12'h020, 32'h0, 0, 1'b0, 1'b1, 1'b0, 0);
        do_txn(1'b1, 12'h024, 32'hA5A5_5A5A, 15, 1'b0, 1'b0, 1'b0, 0);
        do_txn(1'b0, 12'h024, 32'h0, 14, 1'b0, 1'b0, 1'b0, 0);
        // Response back-pressure.
        do_txn(1'b0, 12'h010, 32'h0, 0, 1'b0, 1'b0, 1'b0, 5);

        // Reset during ACCESS drops the bus with no response.
        s_hang = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_access", {psel, penable}, 2'b11);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_access", {psel, penable, rsp_valid, cmd_ready}, 4'b0001);
        s_hang = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("after_reset", {cmd_ready, psel, rsp_valid}, 3'b100);
        do_txn(1'b1, 12'h040, 32'h0BAD_CAFE, 1, 1'b0, 1'b0, 1'b0, 0);
        do_txn(1'b0, 12'h040, 32'h0, 0, 1'b0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom);
            addr = {4'h1, 6'($urandom_range(0, 15)), 2'b00};
            hang = ($urandom_range(0, 15) == 0);
            do_txn(wr, addr, $urandom, int'($urandom_range(0, 4)),
                   ($urandom_range(0, 7) == 0), hang, 1'b0, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
